btn_pulse: RTL and testbench

BTN_PULSE -- requirements
Module: btn_pulse

---
 rtl/btn_pulse.sv | 140 ++++++++++++++
 tb/tb_btn_pulse.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_pulse
// Purpose  : Synchronise and debounce a push-button; emit a press pulse plus
//            optional auto-repeat pulses while the button stays held.
// Revision : 1.0
// ============================================================================
module btn_pulse #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int REPEAT_EN       = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic pulse_out,
   output logic level_out,
   output logic held_out
);

   localparam logic [25:0] C_DB_LAST    = 26'(DEBOUNCE_CYCLES - 1);
   localparam logic [25:0] C_DELAY_LAST = 26'(REPEAT_DELAY - 1);
   localparam logic [25:0] C_RATE_LAST  = 26'(REPEAT_RATE - 1);
   localparam logic        C_RPT_ON     = (REPEAT_EN != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   logic        sync1_q;
   logic        sync2_q;
   logic [25:0] db_cnt_q;
   logic [25:0] db_cnt_d;
   logic        level_q;
   logic        level_d;
   logic        mismatch;
   logic        db_done;
   logic        rise;
   logic        fall;

   state_t      state_q;
   logic [25:0] rpt_cnt_q;
   logic        pulse_q;
   logic        held_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Level accepts a change only after DEBOUNCE_CYCLES consecutive mismatches.
   always_comb begin
      mismatch = (sync2_q != level_q);
      db_done  = mismatch && (db_cnt_q == C_DB_LAST);
      rise     = db_done && !level_q;
      fall     = db_done && level_q;
      level_d  = level_q ^ db_done;
      if (!mismatch || db_done) begin
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 26'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt_q <= '0;
         level_q  <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
      end
   end

   // Release has priority over any repeat terminal count in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rpt_cnt_q <= '0;
         pulse_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (fall) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
            held_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (rise) begin
                     pulse_q   <= 1'b1;
                     state_q   <= ST_HOLD;
                     rpt_cnt_q <= '0;
                  end
               end
               ST_HOLD: begin
                  if (C_RPT_ON) begin
                     if (rpt_cnt_q == C_DELAY_LAST) begin
                        pulse_q   <= 1'b1;
                        held_q    <= 1'b1;
                        state_q   <= ST_REPEAT;
                        rpt_cnt_q <= '0;
                     end else begin
                        rpt_cnt_q <= rpt_cnt_q + 26'd1;
                     end
                  end
               end
               ST_REPEAT: begin
                  if (rpt_cnt_q == C_RATE_LAST) begin
                     pulse_q   <= 1'b1;
                     rpt_cnt_q <= '0;
                  end else begin
                     rpt_cnt_q <= rpt_cnt_q + 26'd1;
                  end
               end
               default: begin
                  state_q   <= ST_IDLE;
                  rpt_cnt_q <= '0;
                  held_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pulse_out = pulse_q;
   assign level_out = level_q;
   assign held_out  = held_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse.sv
`default_nettype none
// Testbench for btn_pulse: scenario tasks compared each cycle against a
// behavioural model of the debounce/press/repeat timing rules.
module tb_btn_pulse;

   localparam int DB   = 4;
   localparam int DLY  = 10;
   localparam int RATE = 3;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic btn_in = 1'b0;
   logic pulse_out, level_out, held_out;
   logic pulse_nr, level_nr, held_nr;

   int tests = 0;
   int fails = 0;

   // Model: m_hist[0] is the input sampled two edges ago, m_hist[1] one edge ago.
   logic [1:0] m_hist     = 2'b00;
   int         m_run      = 0;
   int         m_t0       = 0;
   int         m_edge     = 0;
   logic       m_level    = 1'b0;
   logic       m_pulse    = 1'b0;
   logic       m_pulse_nr = 1'b0;
   logic       m_held     = 1'b0;

   logic [5:0] dut_vec;
   logic [5:0] exp_vec;
   assign dut_vec = {level_out, pulse_out, held_out, level_nr, pulse_nr, held_nr};
   assign exp_vec = {m_level, m_pulse, m_held, m_level, m_pulse_nr, 1'b0};

   btn_pulse #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(1)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .pulse_out(pulse_out), .level_out(level_out), .held_out(held_out)
   );

   btn_pulse #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(0)
   ) dut_nr (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .pulse_out(pulse_nr), .level_out(level_nr), .held_out(held_nr)
   );

   always #5 clk = ~clk;

   // Advance one clock edge, update the model, then settle before sampling.
   task automatic step();
      logic s;
      int   k;
      @(posedge clk);
      if (rst) begin
         m_hist     = 2'b00;
         m_run      = 0;
         m_level    = 1'b0;
         m_pulse    = 1'b0;
         m_pulse_nr = 1'b0;
         m_held     = 1'b0;
      end else begin
         s          = m_hist[0];
         m_hist     = {btn_in, m_hist[1]};
         m_pulse    = 1'b0;
         m_pulse_nr = 1'b0;
         if (s != m_level) begin
            m_run++;
            if (m_run == DB) begin
               m_level = s;
               m_run   = 0;
               if (s) begin
                  m_t0       = m_edge;
                  m_pulse    = 1'b1;
                  m_pulse_nr = 1'b1;
               end
            end
         end else begin
            m_run = 0;
         end
         k = m_edge - m_t0;
         if (m_level && k >= DLY && ((k - DLY) % RATE) == 0) m_pulse = 1'b1;
         m_held = m_level && (k >= DLY);
      end
      m_edge++;
      #1;
   endtask

   task automatic test_reset();
      int n;
      rst    = 1'b1;
      btn_in = 1'b1;
      repeat (2) begin
         step();
         tests++;
         if ({level_out, pulse_out, held_out} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 000", {level_out, pulse_out, held_out});
         end
      end
      rst = 1'b0;
      n   = 0;
      do begin
         step();
         n++;
         tests++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL reset_model edge %0d: got %b, required %b", m_edge, dut_vec, exp_vec);
         end
      end while (level_out !== 1'b1 && n < 20);
      tests++;
      if (n != 6 || pulse_out !== 1'b1) begin
         fails++;
         $display("FAIL reset_press_latency: got %0d edges pulse %b, required 6 edges pulse 1", n, pulse_out);
      end
      step();
      tests++;
      if (pulse_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_pulse_width: got %b, required 0", pulse_out);
      end
      btn_in = 1'b0;
      repeat (10) step();
   endtask

   task automatic test_clean_press();
      int n;
      repeat (5) step();
      btn_in = 1'b1;
      n = 0;
      do begin
         step();
         n++;
         tests++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL press_model edge %0d: got %b, required %b", m_edge, dut_vec, exp_vec);
         end
      end while (level_out !== 1'b1 && n < 20);
      tests++;
      if (n != 6 || pulse_out !== 1'b1 || pulse_nr !== 1'b1) begin
         fails++;
         $display("FAIL press_latency: got %0d edges pulse %b/%b, required 6 edges pulse 1/1", n, pulse_out, pulse_nr);
      end
      step();
      tests++;
      if (pulse_out !== 1'b0 || level_out !== 1'b1) begin
         fails++;
         $display("FAIL press_after: got pulse %b level %b, required pulse 0 level 1", pulse_out, level_out);
      end
      btn_in = 1'b0;
      repeat (10) step();
   endtask

   task automatic test_bounce();
      logic [6:0] pat;
      pat = 7'b1110111;
      for (int i = 0; i < 17; i++) begin
         btn_in = (i < 7) ? pat[6 - i] : 1'b0;
         step();
         tests++;
         if (level_out !== 1'b0 || pulse_out !== 1'b0 || dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL bounce edge %0d: got %b, required %b (level/pulse 0)", m_edge, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_hold();
      int n;
      int first_held;
      int nr_pulses;
      int got[$];
      int want[$];
      bit ok;
      btn_in = 1'b1;
      n = 0;
      do begin step(); n++; end while (level_out !== 1'b1 && n < 20);
      tests++;
      if (n != 6) begin
         fails++;
         $display("FAIL hold_press_latency: got %0d, required 6", n);
      end
      first_held = -1;
      nr_pulses  = 0;
      for (int k = 1; k <= 41; k++) begin
         step();
         tests++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL hold_model rel %0d: got %b, required %b", k, dut_vec, exp_vec);
         end
         if (pulse_out === 1'b1) got.push_back(k);
         if (held_out === 1'b1 && first_held < 0) first_held = k;
         if (pulse_nr === 1'b1) nr_pulses++;
         if (k >= DLY && ((k - DLY) % RATE) == 0) want.push_back(k);
      end
      ok = (got.size() == want.size());
      for (int i = 0; i < got.size() && ok; i++) ok = (got[i] == want[i]);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL hold_pulse_times: got %0d pulses first %0d, required %0d pulses first %0d",
                  got.size(), (got.size() > 0) ? got[0] : -1, want.size(), want[0]);
      end
      tests++;
      if (first_held != DLY) begin
         fails++;
         $display("FAIL hold_held_start: got %0d, required %0d", first_held, DLY);
      end
      tests++;
      if (nr_pulses != 0) begin
         fails++;
         $display("FAIL hold_no_repeat: got %0d pulses, required 0", nr_pulses);
      end
      btn_in = 1'b0;
      n = 0;
      do begin step(); n++; end while (level_out !== 1'b0 && n < 20);
      tests++;
      if (n != 6 || pulse_out !== 1'b0 || held_out !== 1'b0) begin
         fails++;
         $display("FAIL hold_release: got %0d edges pulse %b held %b, required 6 edges 0 0", n, pulse_out, held_out);
      end
      repeat (5) step();
   endtask

   task automatic test_release_on_terminal();
      int n;
      btn_in = 1'b1;
      n = 0;
      do begin step(); n++; end while (level_out !== 1'b1 && n < 20);
      // Release so the fall lands on press+16, a repeat terminal count.
      repeat (10) step();
      btn_in = 1'b0;
      n = 0;
      do begin
         step();
         n++;
         tests++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL term_model edge %0d: got %b, required %b", m_edge, dut_vec, exp_vec);
         end
      end while (level_out !== 1'b0 && n < 20);
      tests++;
      if (n != 6 || pulse_out !== 1'b0 || held_out !== 1'b0) begin
         fails++;
         $display("FAIL term_release: got %0d edges pulse %b held %b, required 6 edges 0 0", n, pulse_out, held_out);
      end
      repeat (5) step();
   endtask

   task automatic test_reset_in_repeat();
      int n;
      btn_in = 1'b1;
      n = 0;
      do begin step(); n++; end while (level_out !== 1'b1 && n < 20);
      repeat (12) step();
      tests++;
      if (held_out !== 1'b1) begin
         fails++;
         $display("FAIL rstrep_held: got %b, required 1", held_out);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if ({level_out, pulse_out, held_out} !== 3'b000) begin
         fails++;
         $display("FAIL rstrep_outputs: got %b, required 000", {level_out, pulse_out, held_out});
      end
      n = 0;
      do begin
         step();
         n++;
         tests++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL rstrep_model edge %0d: got %b, required %b", m_edge, dut_vec, exp_vec);
         end
      end while (level_out !== 1'b1 && n < 20);
      tests++;
      if (n != 6 || pulse_out !== 1'b1) begin
         fails++;
         $display("FAIL rstrep_repress: got %0d edges pulse %b, required 6 edges pulse 1", n, pulse_out);
      end
      btn_in = 1'b0;
      repeat (10) step();
   endtask

   task automatic test_random();
      int run;
      for (int c = 0; c < 3000; c++) begin
         if (run <= 0) begin
            btn_in = ($urandom_range(0, 1) == 1);
            run    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 45)) : int'($urandom_range(1, 8));
         end
         run--;
         rst = ($urandom_range(0, 199) == 0);
         step();
         tests++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL random edge %0d: got %b, required %b", m_edge, dut_vec, exp_vec);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold();
      test_release_on_terminal();
      test_reset_in_repeat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
